axi_light_mem_bridge: RTL

- AXI4-lite slave that terminates the processor-side `if_axi_light` master port and drives a single-ported, valid/ready native memory bus toward the node-local RAM/ROM.
- Buffers one address-write (AW), one write-data (W) and one address-read (AR) beat independently.
- Serialises reads and writes onto the memory bus with alternating priority, then returns the B or R response.
- Accesses outside the configured window are answered locally without touching memory.

---
 rtl/axi_light_mem_pkg.sv | 19 +
 rtl/axi_light_mem_bridge_if.sv | 37 +++
 rtl/axi_light_skid1.sv | 38 +++
 rtl/axi_light_mem_bridge.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/axi_light_mem_pkg.sv
// Shared state encoding and address-window helper for the AXI4-lite to
// native memory bridge.
package axi_light_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_MEM  = 3'd1,
    RD_MEM  = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/axi_light_mem_bridge_if.sv
// AXI4-lite channel bundle (no response codes) shared by processor-side
// masters and the memory bridge.
interface if_axi_light;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, input rready
  );
endinterface

// File: rtl/axi_light_skid1.sv
// Single-entry holding register: accepts a beat only while empty and keeps
// it until the consumer pops it, so ready is a pure register output.
module axi_light_skid1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_pop,
  output logic [WIDTH-1:0] out_data
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;

  // Capture when empty, release on pop; the two never coincide.
  always_ff @(posedge clk) begin
    if (res) begin
      full_r <= 1'b0;
      data_r <= {WIDTH{1'b0}};
    end else if (!full_r && in_valid) begin
      full_r <= 1'b1;
      data_r <= in_data;
    end else if (out_pop) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign in_ready  = !full_r;
  assign out_valid = full_r;
  assign out_data  = data_r;

endmodule

// File: rtl/axi_light_mem_bridge.sv
// AXI4-lite slave that serialises buffered reads and writes onto a single
// valid/ready memory port, answering out-of-window accesses locally.
module axi_light_mem_bridge
  import axi_light_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] MISS_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        res,
  if_axi_light.slave  s_axi,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t      state_r;
  logic        prio_wr_r;
  logic        mem_valid_r, mem_we_r, bvalid_r, rvalid_r;
  logic [31:0] mem_addr_r, mem_wdata_r, rdata_r;
  logic [3:0]  mem_wstrb_r;

  logic        aw_ready_s, w_ready_s, ar_ready_s;
  logic        aw_full_s, w_full_s, ar_full_s;
  logic [31:0] aw_addr_s, ar_addr_s;
  logic [35:0] w_data_s;
  logic        wr_pop_s, rd_pop_s, take_wr_s, take_rd_s;
  logic        wr_pend_s, rd_pend_s, wr_hit_s, rd_hit_s;
  logic        prot_unused_s;

  axi_light_skid1 #(.WIDTH(32)) u_aw (
    .clk(clk), .res(res), .in_valid(s_axi.awvalid), .in_ready(aw_ready_s),
    .in_data(s_axi.awaddr), .out_valid(aw_full_s), .out_pop(wr_pop_s), .out_data(aw_addr_s)
  );

  axi_light_skid1 #(.WIDTH(36)) u_w (
    .clk(clk), .res(res), .in_valid(s_axi.wvalid), .in_ready(w_ready_s),
    .in_data({s_axi.wdata, s_axi.wstrb}), .out_valid(w_full_s), .out_pop(wr_pop_s),
    .out_data(w_data_s)
  );

  axi_light_skid1 #(.WIDTH(32)) u_ar (
    .clk(clk), .res(res), .in_valid(s_axi.arvalid), .in_ready(ar_ready_s),
    .in_data(s_axi.araddr), .out_valid(ar_full_s), .out_pop(rd_pop_s), .out_data(ar_addr_s)
  );

  assign s_axi.awready = aw_ready_s;
  assign s_axi.wready  = w_ready_s;
  assign s_axi.arready = ar_ready_s;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.rvalid  = rvalid_r;
  assign s_axi.rdata   = rdata_r;
  assign prot_unused_s = ^{s_axi.awprot, s_axi.arprot};

  assign wr_pend_s = aw_full_s && w_full_s;
  assign rd_pend_s = ar_full_s;
  assign wr_hit_s  = addr_hit(aw_addr_s, ADDR_BASE, ADDR_MASK);
  assign rd_hit_s  = addr_hit(ar_addr_s, ADDR_BASE, ADDR_MASK);

  // Arbitration out of IDLE and the buffer releases for this cycle.
  always_comb begin
    take_wr_s = 1'b0;
    take_rd_s = 1'b0;
    wr_pop_s  = 1'b0;
    rd_pop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_pend_s && (!rd_pend_s || prio_wr_r)) begin
          take_wr_s = 1'b1;
          wr_pop_s  = !wr_hit_s;
        end else if (rd_pend_s) begin
          take_rd_s = 1'b1;
          rd_pop_s  = !rd_hit_s;
        end else begin
          take_wr_s = 1'b0;
        end
      end
      WR_MEM:  wr_pop_s = mem_ready;
      RD_MEM:  rd_pop_s = mem_ready;
      default: take_wr_s = 1'b0;
    endcase
  end

  // Transaction FSM; every bus output is a register updated on transitions.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r     <= IDLE;
      prio_wr_r   <= 1'b1;
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wstrb_r <= 4'h0;
      bvalid_r    <= 1'b0;
      rvalid_r    <= 1'b0;
      rdata_r     <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (take_wr_s) begin
            prio_wr_r <= 1'b0;
            if (wr_hit_s) begin
              state_r     <= WR_MEM;
              mem_valid_r <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {aw_addr_s[31:2], 2'b00};
              mem_wdata_r <= w_data_s[35:4];
              mem_wstrb_r <= w_data_s[3:0];
            end else begin
              state_r  <= WR_RESP;
              bvalid_r <= 1'b1;
            end
          end else if (take_rd_s) begin
            prio_wr_r <= 1'b1;
            if (rd_hit_s) begin
              state_r     <= RD_MEM;
              mem_valid_r <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= {ar_addr_s[31:2], 2'b00};
              mem_wstrb_r <= 4'h0;
            end else begin
              state_r  <= RD_RESP;
              rvalid_r <= 1'b1;
              rdata_r  <= MISS_RDATA;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WR_MEM: begin
          if (mem_ready) begin
            state_r     <= WR_RESP;
            mem_valid_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wstrb_r <= 4'h0;
            bvalid_r    <= 1'b1;
          end
        end
        RD_MEM: begin
          if (mem_ready) begin
            state_r     <= RD_RESP;
            mem_valid_r <= 1'b0;
            rdata_r     <= mem_rdata;
            rvalid_r    <= 1'b1;
          end
        end
        WR_RESP: begin
          if (s_axi.bready) begin
            state_r  <= IDLE;
            bvalid_r <= 1'b0;
          end
        end
        RD_RESP: begin
          if (s_axi.rready) begin
            state_r  <= IDLE;
            rvalid_r <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;

endmodule
